// File: rtl/apb_wdt.sv
// APB watchdog timer: a down-counter that raises an interrupt on first expiry
// and requests a 4-cycle system reset on a second, unserviced expiry.
module apb_wdt (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        wdt_irq,
    output logic        wdt_rst_n
);

    localparam logic [31:0] KEY        = 32'h1ACC_E551;
    localparam logic [3:0]  IDX_CTRL   = 4'd0;
    localparam logic [3:0]  IDX_LOAD   = 4'd1;
    localparam logic [3:0]  IDX_VALUE  = 4'd2;
    localparam logic [3:0]  IDX_KICK   = 4'd3;
    localparam logic [3:0]  IDX_STATUS = 4'd4;
    localparam logic [3:0]  IDX_LOCK   = 4'd5;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] value_q, value_d;
    logic        irq_pend_q, irq_pend_d;
    logic        rstocc_q, rstocc_d;
    logic        locked_q, locked_d;
    logic        wait_q, wait_d;
    logic [2:0]  pcnt_q, pcnt_d;

    logic [3:0]  idx;
    logic        access;
    logic        bad;
    logic        wr_ok;
    logic        rd_ok;
    logic        kick;
    logic        en_rise;
    logic        expiry;
    logic        irq_set;
    logic        rst_hit;
    logic        w1c;
    logic        unused_addr;

    assign unused_addr = ^paddr[31:4];

    // Bus decode. Handshake: a transfer completes in the cycle where
    // psel & penable & pready are all high; writes complete in the first
    // access cycle, reads in the second (wait_q marks the wait state).
    always_comb begin
        idx     = paddr[3:0];
        access  = psel & penable & presetn;
        bad     = (idx > IDX_LOCK)
                | (!pwrite && idx == IDX_KICK)
                | (pwrite && idx == IDX_VALUE)
                | (pwrite && locked_q && (idx == IDX_CTRL || idx == IDX_LOAD));
        pready  = access & (pwrite | wait_q);
        pslverr = pready & bad;
        wr_ok   = pready & pwrite & ~bad;
        rd_ok   = pready & ~pwrite & ~bad;
        prdata  = 32'h0;
        if (rd_ok) begin
            case (idx)
                IDX_CTRL:   prdata = {29'h0, ctrl_q};
                IDX_LOAD:   prdata = load_q;
                IDX_VALUE:  prdata = value_q;
                IDX_STATUS: prdata = {30'h0, rstocc_q, irq_pend_q};
                IDX_LOCK:   prdata = {31'h0, locked_q};
                default:    prdata = 32'h0;
            endcase
        end
    end

    // Register writes and watchdog next-state.
    always_comb begin
        wait_d = wait_q;
        if (!psel) begin
            wait_d = 1'b0;
        end else if (access && !pwrite) begin
            wait_d = ~wait_q;
        end

        ctrl_d   = ctrl_q;
        load_d   = load_q;
        locked_d = locked_q;
        if (wr_ok && idx == IDX_CTRL) ctrl_d = pwdata[2:0];
        if (wr_ok && idx == IDX_LOAD) load_d = pwdata;
        if (wr_ok && idx == IDX_LOCK) locked_d = (pwdata != KEY);

        kick    = wr_ok && idx == IDX_KICK && pwdata == KEY;
        en_rise = ctrl_d[0] & ~ctrl_q[0];
        // A kick landing on the expiry edge suppresses the expiry entirely.
        expiry  = ctrl_q[0] && value_q == 32'h0 && !kick;
        irq_set = expiry & ~irq_pend_q;
        rst_hit = expiry & irq_pend_q & ctrl_q[1];
        w1c     = wr_ok && idx == IDX_STATUS;

        value_d = value_q;
        if (en_rise || kick || expiry) begin
            value_d = load_q;
        end else if (ctrl_q[0]) begin
            value_d = value_q - 32'd1;
        end

        // Set events are applied after the W1C clear so they win a collision.
        irq_pend_d = irq_pend_q;
        if (w1c && pwdata[0]) irq_pend_d = 1'b0;
        if (irq_set)          irq_pend_d = 1'b1;
        if (kick)             irq_pend_d = 1'b0;

        rstocc_d = rstocc_q;
        if (w1c && pwdata[1]) rstocc_d = 1'b0;
        if (rst_hit)          rstocc_d = 1'b1;

        pcnt_d = pcnt_q;
        if (rst_hit && pcnt_q == 3'd0) begin
            pcnt_d = 3'd4;
        end else if (pcnt_q != 3'd0) begin
            pcnt_d = pcnt_q - 3'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl_q     <= 3'h0;
            load_q     <= 32'hFFFF_FFFF;
            value_q    <= 32'hFFFF_FFFF;
            irq_pend_q <= 1'b0;
            rstocc_q   <= 1'b0;
            locked_q   <= 1'b1;
            wait_q     <= 1'b0;
            pcnt_q     <= 3'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            value_q    <= value_d;
            irq_pend_q <= irq_pend_d;
            rstocc_q   <= rstocc_d;
            locked_q   <= locked_d;
            wait_q     <= wait_d;
            pcnt_q     <= pcnt_d;
        end
    end

    assign wdt_irq   = irq_pend_q & ctrl_q[2];
    assign wdt_rst_n = (pcnt_q == 3'd0);

endmodule

// File: tb/tb_apb_wdt.sv
// Directed bench for apb_wdt: APB transfers push expected {pslverr, prdata}
// into a queue that a negedge monitor pops on every completing cycle.
module tb_apb_wdt;

    localparam logic [31:0] KEY = 32'h1ACC_E551;

    logic        pclk;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        wdt_irq;
    logic        wdt_rst_n;

    logic [32:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    apb_wdt dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .wdt_irq   (wdt_irq),
        .wdt_rst_n (wdt_rst_n)
    );

    // Clock and reset defaults
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge pclk) begin
        if (pready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 33'h1, 33'h0);
            end else begin
                check("xfer_response", {pslverr, prdata}, exp_q.pop_front());
            end
        end else begin
            check("idle_outputs_zero", {pslverr, prdata}, 33'h0);
        end
    end

    // One APB transfer; returns just after the completing edge.
    task automatic xfer(input logic wr, input logic [3:0] idx, input logic [31:0] data,
                        input logic [31:0] exp_rd, input logic exp_err);
        int  waits;
        bit  done;
        exp_q.push_back({exp_err, (wr || exp_err) ? 32'h0 : exp_rd});
        @(posedge pclk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = {$urandom_range(0, 32'h0FFF_FFFF), 4'h0} | {28'h0, idx};
        pwrite  = wr;
        pwdata  = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits   = 0;
        done    = 1'b0;
        for (int k = 0; k < 4 && !done; k++) begin
            @(negedge pclk);
            if (pready === 1'b1) begin
                done = 1'b1;
            end else begin
                waits++;
                @(posedge pclk); #1;
            end
        end
        check("xfer_completed", {32'h0, done}, 33'h1);
        check("xfer_wait_states", waits, wr ? 0 : 1);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] data, input logic err);
        xfer(1'b1, idx, data, 32'h0, err);
    endtask

    task automatic rd(input logic [3:0] idx, input logic [31:0] exp, input logic err);
        xfer(1'b0, idx, 32'h0, exp, err);
    endtask

    initial begin
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        paddr   = 32'h0;
        pwrite  = 1'b0;
        pwdata  = 32'h0;
        repeat (2) @(posedge pclk);
        #1;
        check("reset_irq", wdt_irq, 1'b0);
        check("reset_rst_n", wdt_rst_n, 1'b1);
        check("reset_pready", pready, 1'b0);
        presetn = 1'b1;

        // Reset values
        rd(4'd0, 32'h0, 1'b0);
        rd(4'd1, 32'hFFFF_FFFF, 1'b0);
        rd(4'd2, 32'hFFFF_FFFF, 1'b0);
        rd(4'd4, 32'h0, 1'b0);
        rd(4'd5, 32'h1, 1'b0);

        // Unlock, LOAD=10, enable at edge E0: VALUE sampled after E3 is 7.
        wr(4'd5, KEY, 1'b0);
        wr(4'd1, 32'd10, 1'b0);
        wr(4'd0, 32'h7, 1'b0);
        rd(4'd2, 32'd7, 1'b0);
        // Disable commits at E7 (last decrement) -> VALUE holds 3.
        wr(4'd0, 32'h0, 1'b0);
        rd(4'd2, 32'd3, 1'b0);

        // Error responses
        rd(4'd4, 32'h0, 1'b0);
        rd(4'd7, 32'h0, 1'b1);
        rd(4'd3, 32'h0, 1'b1);
        wr(4'd2, 32'h55, 1'b1);
        rd(4'd2, 32'd3, 1'b0);

        // LOAD=5, enable at E0: IRQ at E6, reset pulse E12..E15.
        wr(4'd1, 32'd5, 1'b0);
        wr(4'd0, 32'h7, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge pclk); #1;
            check("irq_before_expiry", wdt_irq, 1'b0);
        end
        @(posedge pclk); #1;
        check("irq_at_first_expiry", wdt_irq, 1'b1);
        for (int i = 7; i <= 11; i++) begin
            @(posedge pclk); #1;
            check("rst_n_before_second_expiry", wdt_rst_n, 1'b1);
        end
        for (int i = 12; i <= 15; i++) begin
            @(posedge pclk); #1;
            check("rst_n_pulse_low", wdt_rst_n, 1'b0);
        end
        @(posedge pclk); #1;
        check("rst_n_pulse_end", wdt_rst_n, 1'b1);
        rd(4'd4, 32'h3, 1'b0);
        wr(4'd0, 32'h0, 1'b0);
        wr(4'd4, 32'h3, 1'b0);
        rd(4'd4, 32'h0, 1'b0);

        // Enable at E0, valid kick commits on the expiry edge E6.
        wr(4'd0, 32'h7, 1'b0);
        repeat (3) @(posedge pclk);
        wr(4'd3, KEY, 1'b0);
        check("kick_on_expiry_no_irq", wdt_irq, 1'b0);
        check("kick_on_expiry_no_rst", wdt_rst_n, 1'b1);
        rd(4'd2, 32'd2, 1'b0);
        // Expiry at E12 sets IRQ; bad kick at E13 is ignored.
        wr(4'd3, 32'h1234_5678, 1'b0);
        check("bad_kick_irq_kept", wdt_irq, 1'b1);
        rd(4'd2, 32'd1, 1'b0);
        wr(4'd0, 32'h4, 1'b0);
        wr(4'd4, 32'h3, 1'b0);
        check("w1c_clears_irq", wdt_irq, 1'b0);

        // Lock protection; KICK still accepted while locked.
        wr(4'd5, 32'h0, 1'b0);
        rd(4'd5, 32'h1, 1'b0);
        wr(4'd0, 32'h0, 1'b1);
        rd(4'd0, 32'h4, 1'b0);
        wr(4'd1, 32'd7, 1'b1);
        rd(4'd1, 32'd5, 1'b0);
        wr(4'd3, KEY, 1'b0);
        rd(4'd2, 32'd5, 1'b0);
        wr(4'd4, 32'h3, 1'b0);
        rd(4'd4, 32'h0, 1'b0);

        // Reset asserted during a read wait state aborts the transfer.
        @(posedge pclk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 32'h1;
        pwrite  = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk); #1;
        presetn = 1'b0;
        #1;
        check("abort_pready", pready, 1'b0);
        check("abort_prdata", {pslverr, prdata}, 33'h0);
        check("abort_irq", wdt_irq, 1'b0);
        check("abort_rst_n", wdt_rst_n, 1'b1);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        rd(4'd1, 32'hFFFF_FFFF, 1'b0);
        rd(4'd2, 32'hFFFF_FFFF, 1'b0);
        rd(4'd0, 32'h0, 1'b0);
        rd(4'd5, 32'h1, 1'b0);

        repeat (2) @(posedge pclk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
